// File: rtl/toysram_wb_pkg.sv
// toysram_wb_pkg
//   Shared definitions for the Wishbone-to-toy-SRAM slave (wb_sram_slave):
//   FSM state encoding, register offsets, default ID value, counter width.
//   The optional read-modify-write path is controlled by TOYSRAM_WB_RMW_EN;
//   the RMW states are always part of the encoding but only used when it is
//   defined.
package toysram_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RMW_WAIT = 3'd2,
    ST_RMW_WR   = 3'd3,
    ST_ACK      = 3'd4
  } state_e;

  // Byte offsets inside the decoded 64 KiB window (bit 15 selects registers).
  localparam logic [15:0] REG_ID    = 16'h8000;
  localparam logic [15:0] REG_CTRL  = 16'h8004;
  localparam logic [15:0] REG_WRCNT = 16'h8008;
  localparam logic [15:0] REG_RDCNT = 16'h800C;

  localparam logic [31:0] ID_DEFAULT = 32'h7059_5352;

  localparam int unsigned CNT_W = 16;

  // Counters are narrower than the bus; reads return them zero-extended.
  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] cnt);
    return {{(32 - CNT_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/wb_sram_be_merge.sv
// wb_sram_be_merge
//   Combinational byte-lane merge used by the read-modify-write path.
//   Ports:
//     sel_i    [3:0]  byte enables; 1 = take the lane from new_i
//     new_i    [31:0] write data from the bus
//     old_i    [31:0] word read back from the SRAM
//     merged_o [31:0] merged word
module wb_sram_be_merge (
  input  logic [3:0]  sel_i,
  input  logic [31:0] new_i,
  input  logic [31:0] old_i,
  output logic [31:0] merged_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_o[gi*8 +: 8] = sel_i[gi] ? new_i[gi*8 +: 8] : old_i[gi*8 +: 8];
  end

endmodule

// File: rtl/wb_sram_slave.sv
// wb_sram_slave
//   Wishbone classic slave that terminates the management-SoC bus inside the
//   user area. Bridges word accesses to a toy SRAM with separate read/write
//   ports and exposes ID / CTRL / WRCNT / RDCNT registers.
//   Optional feature macro: TOYSRAM_WB_RMW_EN -- when defined, partial-word
//   writes run a read-modify-write sequence; otherwise they are acked and
//   dropped.
//   Ports:
//     wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//     wbs_cyc_i/stb_i/we_i          Wishbone cycle, strobe, write enable
//     wbs_sel_i [3:0]               byte enables
//     wbs_adr_i/dat_i [31:0]        byte address, write data
//     wbs_ack_o, wbs_dat_o [31:0]   registered acknowledge / read data
//     sram_rd_en, sram_rd_adr       SRAM read strobe / word address
//     sram_rd_dat [31:0]            SRAM read data
//     sram_wr_en, sram_wr_adr/dat   SRAM write strobe / word address / data
module wb_sram_slave
  import toysram_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_0000,
  parameter int unsigned AW       = 6,
  parameter int unsigned RD_LAT   = 1,   // legal range 1..4
  parameter logic [31:0] ID_VAL   = ID_DEFAULT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          sram_rd_en,
  output logic [AW-1:0] sram_rd_adr,
  input  logic [31:0]   sram_rd_dat,
  output logic          sram_wr_en,
  output logic [AW-1:0] sram_wr_adr,
  output logic [31:0]   sram_wr_dat
);

  localparam logic [2:0]       LAT_LAST = 3'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic             ack_q, rd_en_q, wr_en_q, ctrl_q;
  logic [31:0]      dat_q, wr_dat_q;
  logic [AW-1:0]    rd_adr_q, wr_adr_q;
  logic [CNT_W-1:0] wrcnt_q, rdcnt_q;
  logic [2:0]       lat_cnt_q;

  logic          req;
  logic [15:0]   reg_off;
  logic [AW-1:0] word_adr;
  logic [31:0]   reg_rdata;

  assign req      = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADR_MASK) == BASE_ADR);
  assign reg_off  = {wbs_adr_i[15:2], 2'b00};
  assign word_adr = wbs_adr_i[AW+1:2];

  always_comb begin
    reg_rdata = '0;
    case (reg_off)
      REG_ID:    reg_rdata = ID_VAL;
      REG_CTRL:  reg_rdata = {31'd0, ctrl_q};
      REG_WRCNT: reg_rdata = zext_cnt(wrcnt_q);
      REG_RDCNT: reg_rdata = zext_cnt(rdcnt_q);
      default:   reg_rdata = '0;
    endcase
  end

`ifdef TOYSRAM_WB_RMW_EN
  // Bus data and byte enables are held locally for the merge so the result
  // does not depend on the master keeping them stable.
  logic [3:0]  sel_q;
  logic [31:0] wdat_q;
  logic [31:0] merged_d;

  wb_sram_be_merge u_merge (
    .sel_i    (sel_q),
    .new_i    (wdat_q),
    .old_i    (sram_rd_dat),
    .merged_o (merged_d)
  );
`endif

  // lat_cnt_q starts at 1 on the edge that raises sram_rd_en; sram_rd_dat is
  // sampled on the RD_LAT-th edge after that one. A dropped cyc always wins
  // over completion so an aborted access never acks or writes.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_adr_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_dat_q  <= '0;
      ctrl_q    <= 1'b0;
      wrcnt_q   <= '0;
      rdcnt_q   <= '0;
      lat_cnt_q <= '0;
`ifdef TOYSRAM_WB_RMW_EN
      sel_q     <= '0;
      wdat_q    <= '0;
`endif
    end else begin
      ack_q   <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            lat_cnt_q <= 3'd1;
`ifdef TOYSRAM_WB_RMW_EN
            sel_q  <= wbs_sel_i;
            wdat_q <= wbs_dat_i;
`endif
            if (wbs_adr_i[15]) begin
              ack_q   <= 1'b1;
              dat_q   <= wbs_we_i ? 32'd0 : reg_rdata;
              state_q <= ST_ACK;
              if (wbs_we_i) begin
                case (reg_off)
                  REG_CTRL:  if (wbs_sel_i[0]) ctrl_q <= wbs_dat_i[0];
                  REG_WRCNT: wrcnt_q <= '0;
                  REG_RDCNT: rdcnt_q <= '0;
                  default:   ;
                endcase
              end
            end else if (!ctrl_q) begin
              // SRAM disabled: quick ack, no strobes, counters untouched.
              ack_q   <= 1'b1;
              dat_q   <= '0;
              state_q <= ST_ACK;
            end else if (!wbs_we_i) begin
              rd_en_q  <= 1'b1;
              rd_adr_q <= word_adr;
              state_q  <= ST_RD_WAIT;
            end else if (wbs_sel_i == 4'hF) begin
              wr_en_q  <= 1'b1;
              wr_adr_q <= word_adr;
              wr_dat_q <= wbs_dat_i;
              ack_q    <= 1'b1;
              dat_q    <= '0;
              wrcnt_q  <= wrcnt_q + CNT_ONE;
              state_q  <= ST_ACK;
`ifdef TOYSRAM_WB_RMW_EN
            end else if (wbs_sel_i != 4'h0) begin
              rd_en_q  <= 1'b1;
              rd_adr_q <= word_adr;
              wr_adr_q <= word_adr;
              state_q  <= ST_RMW_WAIT;
`endif
            end else begin
              // Nothing to write: ack and drop.
              ack_q   <= 1'b1;
              dat_q   <= '0;
              state_q <= ST_ACK;
            end
          end
        end
        ST_RD_WAIT: begin
          if (!wbs_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (lat_cnt_q == LAT_LAST) begin
            ack_q   <= 1'b1;
            dat_q   <= sram_rd_dat;
            rdcnt_q <= rdcnt_q + CNT_ONE;
            state_q <= ST_ACK;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
`ifdef TOYSRAM_WB_RMW_EN
        ST_RMW_WAIT: begin
          if (!wbs_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (lat_cnt_q == LAT_LAST) begin
            wr_dat_q <= merged_d;
            state_q  <= ST_RMW_WR;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
        ST_RMW_WR: begin
          if (!wbs_cyc_i) begin
            state_q <= ST_IDLE;
          end else begin
            wr_en_q <= 1'b1;
            ack_q   <= 1'b1;
            dat_q   <= '0;
            wrcnt_q <= wrcnt_q + CNT_ONE;
            state_q <= ST_ACK;
          end
        end
`endif
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign sram_rd_en  = rd_en_q;
  assign sram_rd_adr = rd_adr_q;
  assign sram_wr_en  = wr_en_q;
  assign sram_wr_adr = wr_adr_q;
  assign sram_wr_dat = wr_dat_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave
//   Directed bench for wb_sram_slave with a reference model feeding a
//   scoreboard queue. The toy SRAM presents read data in the cycle where
//   sram_rd_en is high (RD_LAT = 1). Follows TOYSRAM_WB_RMW_EN when defined.
module tb_wb_sram_slave;

  typedef struct packed {
    logic [3:0]  lat;    // 0 = no ack expected
    logic [31:0] rdat;
    logic [1:0]  n_rd;
    logic [1:0]  n_wr;
    logic [5:0]  wadr;
    logic [31:0] wdat;
  } exp_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        sram_rd_en, sram_wr_en;
  logic [5:0]  sram_rd_adr, sram_wr_adr;
  logic [31:0] sram_rd_dat, sram_wr_dat;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        ref_ctrl;
  logic [15:0] ref_wrcnt, ref_rdcnt;
  logic [31:0] ref_dat_o;
  int          rd_strobes = 0, wr_strobes = 0;
  int          checks = 0, errors = 0;
  exp_t        sb [$];

  wb_sram_slave dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i), .wbs_stb_i (wbs_stb_i), .wbs_we_i (wbs_we_i),
    .wbs_sel_i (wbs_sel_i), .wbs_adr_i (wbs_adr_i), .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o), .wbs_dat_o (wbs_dat_o),
    .sram_rd_en (sram_rd_en), .sram_rd_adr (sram_rd_adr), .sram_rd_dat (sram_rd_dat),
    .sram_wr_en (sram_wr_en), .sram_wr_adr (sram_wr_adr), .sram_wr_dat (sram_wr_dat)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  // Toy SRAM: flow-through read while strobed, write on the clock edge.
  assign sram_rd_dat = sram_rd_en ? mem[sram_rd_adr] : 32'hBAD0_BAD0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1111_0000 + 32'(i);
    forever @(posedge wb_clk_i) if (sram_wr_en) mem[sram_wr_adr] <= sram_wr_dat;
  end

  initial forever @(posedge wb_clk_i) begin
    if (sram_rd_en) rd_strobes <= rd_strobes + 1;
    if (sram_wr_en) wr_strobes <= wr_strobes + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] wdat, output exp_t e);
    logic [5:0]  w;
    logic [31:0] m;
    e = '0;
    w = adr[7:2];
    if (adr[31:16] != 16'h3000) return;
    e.lat = 4'd1;
    if (adr[15]) begin
      if (!we) begin
        case (adr[15:0] & 16'hFFFC)
          16'h8000: e.rdat = 32'h7059_5352;
          16'h8004: e.rdat = {31'd0, ref_ctrl};
          16'h8008: e.rdat = {16'd0, ref_wrcnt};
          16'h800C: e.rdat = {16'd0, ref_rdcnt};
          default:  e.rdat = 32'd0;
        endcase
      end else begin
        case (adr[15:0] & 16'hFFFC)
          16'h8004: if (sel[0]) ref_ctrl = wdat[0];
          16'h8008: ref_wrcnt = 16'd0;
          16'h800C: ref_rdcnt = 16'd0;
          default:  ;
        endcase
      end
    end else if (!ref_ctrl) begin
      e.rdat = 32'd0;
    end else if (!we) begin
      e.lat = 4'd2; e.n_rd = 2'd1; e.rdat = ref_mem[w];
      ref_rdcnt = ref_rdcnt + 16'd1;
    end else if (sel == 4'hF) begin
      e.n_wr = 2'd1; e.wadr = w; e.wdat = wdat;
      ref_mem[w] = wdat; ref_wrcnt = ref_wrcnt + 16'd1;
`ifdef TOYSRAM_WB_RMW_EN
    end else if (sel != 4'h0) begin
      m = ref_mem[w];
      for (int b = 0; b < 4; b++) if (sel[b]) m[b*8 +: 8] = wdat[b*8 +: 8];
      e.lat = 4'd3; e.n_rd = 2'd1; e.n_wr = 2'd1; e.wadr = w; e.wdat = m;
      ref_mem[w] = m; ref_wrcnt = ref_wrcnt + 16'd1;
`endif
    end
    if (e.lat != 0) ref_dat_o = e.rdat;
  endtask

  task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] wdat, input string tag);
    exp_t        e, x;
    int          rd0, wr0, lat;
    logic        a_wr_en;
    logic [5:0]  a_wr_adr;
    logic [31:0] a_wr_dat, a_dat;
    predict(we, sel, adr, wdat, e);
    sb.push_back(e);
    @(negedge wb_clk_i);
    rd0 = rd_strobes; wr0 = wr_strobes;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = wdat;
    lat = 0; a_wr_en = 1'b0; a_wr_adr = '0; a_wr_dat = '0; a_dat = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        lat = i; a_wr_en = sram_wr_en; a_wr_adr = sram_wr_adr;
        a_wr_dat = sram_wr_dat; a_dat = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    x = sb.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(x.lat));
    if (x.lat != 0) begin
      check({tag, " dat_o"}, a_dat, x.rdat);
      check({tag, " wr_en@ack"}, {31'd0, a_wr_en}, 32'(x.n_wr));
      if (x.n_wr != 0) begin
        check({tag, " wr_adr"}, 32'(a_wr_adr), 32'(x.wadr));
        check({tag, " wr_dat"}, a_wr_dat, x.wdat);
      end
      check({tag, " ack_one_cycle"}, {31'd0, wbs_ack_o}, 32'd0);
    end
    check({tag, " rd_strobes"}, 32'(rd_strobes - rd0), 32'(x.n_rd));
    check({tag, " wr_strobes"}, 32'(wr_strobes - wr0), 32'(x.n_wr));
    $display("txn %-14s we=%0b sel=%h adr=%h lat=%0d dat_o=%h", tag, we, sel, adr, lat, a_dat);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ack"}, {31'd0, wbs_ack_o}, 32'd0);
    check({tag, " dat_o"}, wbs_dat_o, 32'd0);
    check({tag, " rd_en"}, {31'd0, sram_rd_en}, 32'd0);
    check({tag, " wr_en"}, {31'd0, sram_wr_en}, 32'd0);
    check({tag, " rd_adr"}, 32'(sram_rd_adr), 32'd0);
    check({tag, " wr_adr"}, 32'(sram_wr_adr), 32'd0);
    check({tag, " wr_dat"}, sram_wr_dat, 32'd0);
  endtask

  initial begin
    int   rd0, wr0;
    logic seen;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1111_0000 + 32'(i);
    ref_ctrl = 1'b0; ref_wrcnt = 16'd0; ref_rdcnt = 16'd0; ref_dat_o = 32'd0;

    repeat (3) @(posedge wb_clk_i);
    #1 check_outputs_zero("reset");
    @(negedge wb_clk_i) wb_rst_i = 1'b0;

    do_txn(1'b0, 4'hF, 32'h3000_8000, 32'd0,         "rd_id");
    do_txn(1'b0, 4'hF, 32'h3000_8004, 32'd0,         "rd_ctrl0");
    do_txn(1'b1, 4'hF, 32'h3000_8004, 32'd1,         "wr_ctrl1");
    do_txn(1'b1, 4'hF, 32'h3000_0010, 32'hDEADBEEF,  "wr_full");
    do_txn(1'b0, 4'hF, 32'h3000_0010, 32'd0,         "rd_word4");
    do_txn(1'b0, 4'hF, 32'h3000_8008, 32'd0,         "rd_wrcnt");
    do_txn(1'b0, 4'hF, 32'h3000_800C, 32'd0,         "rd_rdcnt");
    do_txn(1'b1, 4'b0010, 32'h3000_0010, 32'h0000_5500, "wr_partial");
    do_txn(1'b0, 4'hF, 32'h3000_0010, 32'd0,         "rd_after_part");
    do_txn(1'b1, 4'h0, 32'h3000_0014, 32'h1234_5678, "wr_sel0");
    do_txn(1'b0, 4'hF, 32'h3000_0014, 32'd0,         "rd_word5");
    do_txn(1'b0, 4'hF, 32'h3000_0100, 32'd0,         "rd_word64b");

    // Abort: drop cyc while the read is outstanding.
    @(negedge wb_clk_i);
    rd0 = rd_strobes; wr0 = wr_strobes;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0010;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen = 1'b1;
    end
    check("abort no_ack", {31'd0, seen}, 32'd0);
    check("abort rd_strobes", 32'(rd_strobes - rd0), 32'd1);
    check("abort wr_strobes", 32'(wr_strobes - wr0), 32'd0);
    check("abort dat_held", wbs_dat_o, ref_dat_o);
    $display("txn abort_read     observed ack=%0b dat_o=%h", seen, wbs_dat_o);

    do_txn(1'b0, 4'hF, 32'h3000_0010, 32'd0,         "rd_post_abort");
    do_txn(1'b0, 4'hF, 32'h3000_800C, 32'd0,         "rd_rdcnt2");
    do_txn(1'b0, 4'hF, 32'h3000_8010, 32'd0,         "rd_unmapped");
    do_txn(1'b1, 4'hF, 32'h3000_8010, 32'hFFFF_FFFF, "wr_unmapped");
    do_txn(1'b1, 4'hF, 32'h3000_8008, 32'h0000_00AA, "clr_wrcnt");
    do_txn(1'b0, 4'hF, 32'h3000_8008, 32'd0,         "rd_wrcnt_clr");
    do_txn(1'b0, 4'hF, 32'h3100_0000, 32'd0,         "miss");
    do_txn(1'b1, 4'hF, 32'h3000_8004, 32'd0,         "wr_ctrl0");
    do_txn(1'b0, 4'hF, 32'h3000_0010, 32'd0,         "rd_disabled");
    do_txn(1'b1, 4'hF, 32'h3000_0018, 32'hCAFE_F00D, "wr_disabled");
    do_txn(1'b1, 4'hF, 32'h3000_8004, 32'd1,         "wr_ctrl1b");
    do_txn(1'b0, 4'hF, 32'h3000_0018, 32'd0,         "rd_word6");

    // Reset while the SRAM read of a pending transaction is in flight.
    @(negedge wb_clk_i);
    wr0 = wr_strobes;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h3000_0010;
`ifdef TOYSRAM_WB_RMW_EN
    wbs_we_i = 1'b1; wbs_sel_i = 4'b0100; wbs_dat_i = 32'h0077_0000;
`else
    wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
`endif
    @(posedge wb_clk_i); #1;
    check("rst_mid rd_issued", {31'd0, sram_rd_en}, 32'd1);
    wb_rst_i = 1'b1;
    #1 check_outputs_zero("rst_mid");
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen = 1'b1;
    end
    check("rst_mid no_ack", {31'd0, seen}, 32'd0);
    check("rst_mid wr_strobes", 32'(wr_strobes - wr0), 32'd0);
    $display("txn reset_midflight observed ack=%0b wr_strobes=%0d", seen, wr_strobes - wr0);
    ref_ctrl = 1'b0; ref_wrcnt = 16'd0; ref_rdcnt = 16'd0; ref_dat_o = 32'd0;

    do_txn(1'b0, 4'hF, 32'h3000_8008, 32'd0,         "rd_wrcnt_rst");
    do_txn(1'b0, 4'hF, 32'h3000_800C, 32'd0,         "rd_rdcnt_rst");
    do_txn(1'b0, 4'hF, 32'h3000_8004, 32'd0,         "rd_ctrl_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
